// File: rtl/grf_wb_arbiter.sv
// Sole driver of the GRF write port: merges never-stalled W-stage writebacks with
// queued MDU results, killing stale queued writes so later W-stage writes win (WAW).
module grf_wb_arbiter #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              w_we,
  input  logic [4:0]        w_addr,
  input  logic [31:0]       w_data,
  input  logic [31:0]       w_pc,
  input  logic              md_valid,
  output logic              md_ready,
  input  logic [4:0]        md_addr,
  input  logic [31:0]       md_data,
  input  logic [31:0]       md_pc,
  output logic              grf_we,
  output logic [4:0]        grf_a3,
  output logic [31:0]       grf_wd,
  output logic [31:0]       grf_pc,
  input  logic [4:0]        query_a,
  output logic              query_pending,
  output logic [PTR_W:0]    fifo_count
);

  localparam logic [PTR_W:0] DEPTH_C = DEPTH[PTR_W:0];

  logic [4:0]       addr_q [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [31:0]      pc_q   [DEPTH];
  logic [DEPTH-1:0] kill_q;

  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q, count_d;

  logic             grf_we_q, grf_we_d;
  logic [4:0]       grf_a3_q, grf_a3_d;
  logic [31:0]      grf_wd_q, grf_wd_d;
  logic [31:0]      grf_pc_q, grf_pc_d;

  logic             w_take, push, pop, empty;
  logic [DEPTH-1:0] occ;
  logic [PTR_W-1:0] off;

  assign empty    = (count_q == '0);
  assign md_ready = reset && (count_q < DEPTH_C);
  assign w_take   = w_we && (w_addr != 5'd0);
  assign push     = md_valid && md_ready && (md_addr != 5'd0);
  assign pop      = !w_take && !empty;

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (!push && pop) count_d = count_q - 1'b1;
  end

  // Output mux: W stage first, then live FIFO head; a killed head pops with we=0.
  always_comb begin
    grf_we_d = 1'b0;
    grf_a3_d = grf_a3_q;
    grf_wd_d = grf_wd_q;
    grf_pc_d = grf_pc_q;
    if (w_take) begin
      grf_we_d = 1'b1;
      grf_a3_d = w_addr;
      grf_wd_d = w_data;
      grf_pc_d = w_pc;
    end else if (!empty && !kill_q[rd_ptr_q]) begin
      grf_we_d = 1'b1;
      grf_a3_d = addr_q[rd_ptr_q];
      grf_wd_d = data_q[rd_ptr_q];
      grf_pc_d = pc_q[rd_ptr_q];
    end
  end

  // An entry is occupied when its distance from the read pointer is below the count.
  always_comb begin
    occ           = '0;
    off           = '0;
    query_pending = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      off    = PTR_W'(i) - rd_ptr_q;
      occ[i] = ({1'b0, off} < count_q);
      if (occ[i] && !kill_q[i] && (addr_q[i] == query_a) && (query_a != 5'd0))
        query_pending = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      kill_q   <= '0;
      grf_we_q <= 1'b0;
      grf_a3_q <= '0;
      grf_wd_q <= '0;
      grf_pc_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (w_take && (addr_q[i] == w_addr)) kill_q[i] <= 1'b1;
      if (push) begin
        kill_q[wr_ptr_q] <= w_take && (md_addr == w_addr);
        wr_ptr_q         <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q  <= count_d;
      grf_we_q <= grf_we_d;
      grf_a3_q <= grf_a3_d;
      grf_wd_q <= grf_wd_d;
      grf_pc_q <= grf_pc_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wr_ptr_q] <= md_addr;
      data_q[wr_ptr_q] <= md_data;
      pc_q[wr_ptr_q]   <= md_pc;
    end
  end

  assign grf_we     = grf_we_q;
  assign grf_a3     = grf_a3_q;
  assign grf_wd     = grf_wd_q;
  assign grf_pc     = grf_pc_q;
  assign fifo_count = count_q;

endmodule

// File: tb/tb_grf_wb_arbiter.sv
// Directed bench for grf_wb_arbiter: hand-computed expectations for writeback
// priority, MDU queueing, WAW kill, zero-register handling and async reset.
module tb_grf_wb_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        w_we;
  logic [4:0]  w_addr;
  logic [31:0] w_data, w_pc;
  logic        md_valid, md_ready;
  logic [4:0]  md_addr;
  logic [31:0] md_data, md_pc;
  logic        grf_we;
  logic [4:0]  grf_a3;
  logic [31:0] grf_wd, grf_pc;
  logic [4:0]  query_a;
  logic        query_pending;
  logic [2:0]  fifo_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  grf_wb_arbiter #(.DEPTH(4), .PTR_W(2)) dut (
    .clk(clk), .reset(reset),
    .w_we(w_we), .w_addr(w_addr), .w_data(w_data), .w_pc(w_pc),
    .md_valid(md_valid), .md_ready(md_ready), .md_addr(md_addr),
    .md_data(md_data), .md_pc(md_pc),
    .grf_we(grf_we), .grf_a3(grf_a3), .grf_wd(grf_wd), .grf_pc(grf_pc),
    .query_a(query_a), .query_pending(query_pending), .fifo_count(fifo_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; w_we = 0; w_addr = 0; w_data = 0; w_pc = 0;
    md_valid = 0; md_addr = 0; md_data = 0; md_pc = 0; query_a = 0;
    #12;
    chk("rst_count", 32'(fifo_count), 0);
    chk("rst_we", 32'(grf_we), 0);
    chk("rst_a3", 32'(grf_a3), 0);
    chk("rst_wd", grf_wd, 0);
    chk("rst_pc", grf_pc, 0);
    chk("rst_ready", 32'(md_ready), 0);
    reset = 1'b1;
    #1;
    chk("rel_ready", 32'(md_ready), 1);
    step();

    // W-stage write, one edge of latency
    w_we = 1; w_addr = 5; w_data = 32'h1234; w_pc = 32'h100;
    step();
    chk("w_we", 32'(grf_we), 1);
    chk("w_a3", 32'(grf_a3), 5);
    chk("w_wd", grf_wd, 32'h1234);
    chk("w_pc", grf_pc, 32'h100);
    w_we = 0;

    // Single MDU result, idle W stage
    md_valid = 1; md_addr = 8; md_data = 32'hCAFE; md_pc = 32'h200; query_a = 8;
    step();
    chk("md_cnt1", 32'(fifo_count), 1);
    chk("md_q8", 32'(query_pending), 1);
    chk("md_we0", 32'(grf_we), 0);
    md_valid = 0;
    step();
    chk("md_we1", 32'(grf_we), 1);
    chk("md_a3", 32'(grf_a3), 8);
    chk("md_wd", grf_wd, 32'hCAFE);
    chk("md_pc", grf_pc, 32'h200);
    chk("md_cnt0", 32'(fifo_count), 0);
    chk("md_q8_gone", 32'(query_pending), 0);
    step();
    chk("md_idle_we", 32'(grf_we), 0);
    chk("md_hold_a3", 32'(grf_a3), 8);
    query_a = 0;

    // Fill FIFO while W writes every cycle
    for (int k = 0; k < 4; k++) begin
      w_we = 1; w_addr = 5'(20 + k); w_data = 32'(k);
      md_valid = 1; md_addr = 5'(10 + k); md_data = 32'hA0 + 32'(k); md_pc = 32'(k);
      step();
      chk("fill_cnt", 32'(fifo_count), 32'(k + 1));
    end
    chk("full_ready", 32'(md_ready), 0);
    chk("full_a3", 32'(grf_a3), 23);
    md_addr = 14; md_data = 32'hA4; w_addr = 24;
    step();
    chk("held_cnt", 32'(fifo_count), 4);
    chk("held_ready", 32'(md_ready), 0);
    chk("held_a3", 32'(grf_a3), 24);
    w_we = 0;
    step();
    chk("dr0_a3", 32'(grf_a3), 10);
    chk("dr0_wd", grf_wd, 32'hA0);
    chk("dr0_cnt", 32'(fifo_count), 3);
    chk("dr0_ready", 32'(md_ready), 1);
    step();
    chk("dr1_a3", 32'(grf_a3), 11);
    chk("dr1_cnt", 32'(fifo_count), 3);
    md_valid = 0;
    step();
    chk("dr2_a3", 32'(grf_a3), 12);
    chk("dr2_cnt", 32'(fifo_count), 2);
    step();
    chk("dr3_a3", 32'(grf_a3), 13);
    chk("dr3_wd", grf_wd, 32'hA3);
    step();
    chk("dr4_a3", 32'(grf_a3), 14);
    chk("dr4_wd", grf_wd, 32'hA4);
    chk("dr4_we", 32'(grf_we), 1);
    chk("dr4_cnt", 32'(fifo_count), 0);
    step();
    chk("dr_idle", 32'(grf_we), 0);

    // WAW: later W-stage write kills the queued MDU entry
    query_a = 9;
    md_valid = 1; md_addr = 9; md_data = 32'hAAAA; md_pc = 32'h300;
    step();
    chk("k_q9", 32'(query_pending), 1);
    md_valid = 0; w_we = 1; w_addr = 9; w_data = 32'hBBBB; w_pc = 32'h304;
    step();
    chk("k_we", 32'(grf_we), 1);
    chk("k_wd", grf_wd, 32'hBBBB);
    chk("k_cnt", 32'(fifo_count), 1);
    chk("k_q9_off", 32'(query_pending), 0);
    w_we = 0;
    step();
    chk("k_silent", 32'(grf_we), 0);
    chk("k_cnt0", 32'(fifo_count), 0);
    chk("k_keep_wd", grf_wd, 32'hBBBB);

    // Same-edge push to the register W writes is pushed already killed
    query_a = 7;
    md_valid = 1; md_addr = 7; md_data = 32'hDEAD;
    w_we = 1; w_addr = 7; w_data = 32'h7777;
    step();
    chk("sk_wd", grf_wd, 32'h7777);
    chk("sk_cnt", 32'(fifo_count), 1);
    chk("sk_q7", 32'(query_pending), 0);
    md_valid = 0; w_we = 0;
    step();
    chk("sk_we", 32'(grf_we), 0);
    chk("sk_wd_hold", grf_wd, 32'h7777);
    query_a = 0;

    // Zero-register handshakes
    md_valid = 1; md_addr = 0; md_data = 32'h1;
    step();
    chk("z_md_cnt", 32'(fifo_count), 0);
    md_valid = 0; w_we = 1; w_addr = 0; w_data = 32'h55;
    step();
    chk("z_w_we", 32'(grf_we), 0);
    chk("z_w_wd", grf_wd, 32'h7777);
    w_we = 0;

    // Async reset mid-drain with 3 entries queued
    for (int k = 0; k < 3; k++) begin
      w_we = 1; w_addr = 20; md_valid = 1; md_addr = 5'(1 + k); md_data = 32'(k);
      step();
    end
    chk("r_cnt3", 32'(fifo_count), 3);
    w_we = 0; md_valid = 0;
    step();
    chk("r_pop_a3", 32'(grf_a3), 1);
    chk("r_cnt2", 32'(fifo_count), 2);
    #2 reset = 1'b0;
    #1;
    chk("r_cnt0", 32'(fifo_count), 0);
    chk("r_we0", 32'(grf_we), 0);
    chk("r_a3", 32'(grf_a3), 0);
    chk("r_ready0", 32'(md_ready), 0);
    #1 reset = 1'b1;
    #1;
    chk("r_ready1", 32'(md_ready), 1);
    step();
    chk("r_after_cnt", 32'(fifo_count), 0);
    chk("r_after_we", 32'(grf_we), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
